// File: rtl/fp_to_int_cvt.sv
// fp_to_int_cvt
//
// Iterative IEEE-754 single-precision to integer converter (RISC-V
// FCVT.W/WU.S, and FCVT.L/LU.S when INT_W=64). Supports signed and unsigned
// targets, RNE/RTZ/RDN/RUP/RMM rounding (rm 5-7 behave as RTZ), saturation
// and the NV/NX flags. The operand is aligned by a multi-cycle shifter that
// moves up to STEP bit positions per cycle.
//
// Parameters:
//   INT_W  integer result width, 32 or 64
//   STEP   maximum shift distance per SHIFT cycle, power of two in 1..32
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   converter idle and able to accept an operand
//   in_a       single-precision operand
//   in_signed  1 = signed target, 0 = unsigned target
//   in_rm      rounding mode
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_z      integer result
//   out_flags  {NV, DZ, OF, UF, NX}; DZ/OF/UF are always 0
module fp_to_int_cvt #(
    parameter int unsigned INT_W = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_z,
    output logic [4:0]       out_flags
);

    // Magnitude carries one extra bit so a rounding carry is never lost.
    localparam int unsigned       MW      = INT_W + 1;
    // Magnitude plus guard bit, shifted as one vector on right shifts.
    localparam int unsigned       EW      = INT_W + 2;
    localparam logic [6:0]        STEP_N  = 7'(STEP);
    localparam logic signed [9:0] INT_W_S = 10'(INT_W);
    localparam logic [4:0]        FLAG_NV = 5'b10000;
    localparam logic [4:0]        FLAG_NX = 5'b00001;

    typedef enum logic [2:0] {
        StIdle,
        StClassify,
        StShift,
        StRound,
        StOut
    } state_t;

    state_t           r_state;
    logic [31:0]      r_a;
    logic             r_is_signed;
    logic [2:0]       r_rm;
    logic             r_sign;
    logic [MW-1:0]    r_mag;
    logic             r_g;
    logic             r_st;
    logic [6:0]       r_n;
    logic             r_left;
    logic             r_out_valid;
    logic [INT_W-1:0] r_z;
    logic [4:0]       r_flags;

    // ------------------------------------------------------------------
    // Classification of the captured operand
    // ------------------------------------------------------------------
    logic [7:0]        w_exp;
    logic [22:0]       w_frac;
    logic              w_sign;
    logic signed [9:0] w_e;
    logic signed [9:0] w_rdist;
    logic [23:0]       w_m;
    logic              w_is_zero;
    logic              w_is_nan;
    logic              w_too_big;
    logic              w_left;
    logic [6:0]        w_n_cls;
    logic [INT_W-1:0]  w_max_val;
    logic [INT_W-1:0]  w_min_val;

    assign w_exp  = r_a[30:23];
    assign w_frac = r_a[22:0];
    assign w_sign = r_a[31];

    always_comb begin
        // Subnormals use e=-126 with a zero hidden bit.
        w_e       = (w_exp == 8'd0) ? -10'sd126 : $signed({2'b00, w_exp}) - 10'sd127;
        w_m       = {(w_exp != 8'd0), w_frac};
        w_is_zero = (w_exp == 8'd0) && (w_frac == 23'd0);
        w_is_nan  = (w_exp == 8'hFF) && (w_frac != 23'd0);
        // Infinity has e=128 and therefore falls in here as well.
        w_too_big = (w_e >= INT_W_S);
        w_left    = (w_e >= 10'sd23);
        w_rdist   = 10'sd23 - w_e;
        if (w_left) begin
            w_n_cls = 7'(w_e - 10'sd23);
        end else if (w_rdist > 10'sd25) begin
            // 25 positions push every magnitude bit past the guard bit.
            w_n_cls = 7'd25;
        end else begin
            w_n_cls = 7'(w_rdist);
        end
    end

    assign w_max_val = r_is_signed ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
    assign w_min_val = r_is_signed ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};

    // ------------------------------------------------------------------
    // Shifter step
    // ------------------------------------------------------------------
    logic [6:0]    w_amt;
    logic [EW-1:0] w_ext;
    logic [EW-1:0] w_ext_sh;
    logic          w_lost;
    logic [MW-1:0] w_mag_left;

    always_comb begin
        w_amt      = (r_n > STEP_N) ? STEP_N : r_n;
        w_ext      = {r_mag, r_g};
        w_ext_sh   = w_ext >> w_amt;
        // Bits falling off the bottom of {mag, g} collapse into sticky.
        w_lost     = |(w_ext & ~({EW{1'b1}} << w_amt));
        w_mag_left = r_mag << w_amt;
    end

    // ------------------------------------------------------------------
    // Rounding and range check
    // ------------------------------------------------------------------
    logic             w_inc;
    logic [MW-1:0]    w_rmag;
    logic [INT_W-1:0] w_rmag_lo;
    logic             w_nx;
    logic [INT_W-1:0] w_rz;
    logic [4:0]       w_rflags;
    logic [MW-1:0]    w_pos_lim;
    logic [MW-1:0]    w_neg_lim;

    assign w_pos_lim = {2'b00, {(INT_W-1){1'b1}}};
    assign w_neg_lim = {2'b01, {(INT_W-1){1'b0}}};

    always_comb begin
        case (r_rm)
            3'd0:    w_inc = r_g & (r_st | r_mag[0]);
            3'd2:    w_inc = r_sign & (r_g | r_st);
            3'd3:    w_inc = ~r_sign & (r_g | r_st);
            3'd4:    w_inc = r_g;
            default: w_inc = 1'b0;
        endcase
        w_rmag    = r_mag + {{(MW-1){1'b0}}, w_inc};
        w_rmag_lo = w_rmag[INT_W-1:0];
        w_nx      = r_g | r_st;

        w_rz     = '0;
        w_rflags = '0;
        if (r_is_signed) begin
            if (!r_sign && (w_rmag > w_pos_lim)) begin
                w_rz     = w_max_val;
                w_rflags = FLAG_NV;
            end else if (r_sign && (w_rmag > w_neg_lim)) begin
                w_rz     = w_min_val;
                w_rflags = FLAG_NV;
            end else begin
                w_rz     = r_sign ? -w_rmag_lo : w_rmag_lo;
                w_rflags = w_nx ? FLAG_NX : 5'b0;
            end
        end else begin
            if (r_sign) begin
                // Any nonzero negative magnitude is out of range.
                w_rz     = '0;
                w_rflags = (w_rmag != '0) ? FLAG_NV : (w_nx ? FLAG_NX : 5'b0);
            end else if (w_rmag[INT_W]) begin
                w_rz     = w_max_val;
                w_rflags = FLAG_NV;
            end else begin
                w_rz     = w_rmag_lo;
                w_rflags = w_nx ? FLAG_NX : 5'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_is_signed <= 1'b0;
            r_rm        <= '0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_g         <= 1'b0;
            r_st        <= 1'b0;
            r_n         <= '0;
            r_left      <= 1'b0;
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_flags     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a         <= in_a;
                        r_is_signed <= in_signed;
                        r_rm        <= in_rm;
                        r_state     <= StClassify;
                    end
                end
                StClassify: begin
                    r_sign <= w_sign;
                    r_g    <= 1'b0;
                    r_st   <= 1'b0;
                    if (w_is_zero) begin
                        r_z         <= '0;
                        r_flags     <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end else if (w_is_nan || (w_too_big && !w_sign)) begin
                        r_z         <= w_max_val;
                        r_flags     <= FLAG_NV;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end else if (w_too_big) begin
                        r_z         <= w_min_val;
                        r_flags     <= FLAG_NV;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end else begin
                        r_mag   <= MW'(w_m);
                        r_n     <= w_n_cls;
                        r_left  <= w_left;
                        r_state <= (w_n_cls == 7'd0) ? StRound : StShift;
                    end
                end
                StShift: begin
                    if (r_left) begin
                        r_mag <= w_mag_left;
                    end else begin
                        {r_mag, r_g} <= w_ext_sh;
                        r_st         <= r_st | w_lost;
                    end
                    r_n <= r_n - w_amt;
                    if (r_n == w_amt) begin
                        r_state <= StRound;
                    end
                end
                StRound: begin
                    r_z         <= w_rz;
                    r_flags     <= w_rflags;
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle) && !rst;
    assign out_valid = r_out_valid;
    assign out_z     = r_z;
    assign out_flags = r_flags;

endmodule

// File: tb/tb_fp_to_int_cvt.sv
// Testbench for fp_to_int_cvt: a 32-bit STEP=1 instance and a 64-bit STEP=8
// instance share the input side and run each operand in parallel; each table
// entry selects which instance's result is compared.
module tb_fp_to_int_cvt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic        in_signed = 1'b0;
    logic [2:0]  in_rm = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] z32;
    logic [63:0] z64;
    logic [4:0]  f32, f64;

    always #5 clk = ~clk;

    fp_to_int_cvt #(.INT_W(32), .STEP(1)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_a(in_a),
        .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov32), .out_ready(out_ready),
        .out_z(z32), .out_flags(f32)
    );

    fp_to_int_cvt #(.INT_W(64), .STEP(8)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_a(in_a),
        .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov64), .out_ready(out_ready),
        .out_z(z64), .out_flags(f64)
    );

    typedef struct {
        logic [31:0] a;
        logic        sg;
        logic [2:0]  rm;
        logic        w64;
        logic [63:0] z;
        logic [4:0]  f;
        int          lat;   // 0 = latency not checked
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] r_z32;
    logic [63:0] r_z64;
    logic [4:0]  r_f32, r_f64;
    int          r_l32, r_l64;

    function automatic vec_t mk(input logic [31:0] a, input logic sg, input logic [2:0] rm,
                                input logic w64, input logic [63:0] z, input logic [4:0] f,
                                input int lat);
        vec_t v;
        v.a = a; v.sg = sg; v.rm = rm; v.w64 = w64; v.z = z; v.f = f; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one operand for a single accept edge; returns #1 after it.
    task automatic launch(input logic [31:0] a, input logic sg, input logic [2:0] rm);
        @(posedge clk); #1;
        in_a = a; in_signed = sg; in_rm = rm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Converts on both instances with out_ready=1; latency is the cycle
    // number (accept edge = cycle 0) at which out_valid is first seen.
    task automatic run(input logic [31:0] a, input logic sg, input logic [2:0] rm);
        int cyc;
        bit d32, d64;
        r_z32 = '0; r_z64 = '0; r_f32 = '0; r_f64 = '0; r_l32 = 0; r_l64 = 0;
        d32 = 1'b0; d64 = 1'b0;
        launch(a, sg, rm);
        cyc = 1;
        while (!(d32 && d64) && cyc < 200) begin
            if (ov32 && !d32) begin
                d32 = 1'b1; r_z32 = z32; r_f32 = f32; r_l32 = cyc;
            end
            if (ov64 && !d64) begin
                d64 = 1'b1; r_z64 = z64; r_f64 = f64; r_l64 = cyc;
            end
            if (!(d32 && d64)) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!(d32 && d64)) check("timeout", {62'b0, d64, d32}, 64'd3);
    endtask

    initial begin
        bit seen;

        // {a, signed, rm, use 64-bit instance, z, flags, latency}
        vecs.push_back(mk(32'h406CCCCD, 1, 3'd0, 0, 64'h4,        5'h01, 25));
        vecs.push_back(mk(32'h406CCCCD, 1, 3'd1, 0, 64'h3,        5'h01, 0));
        vecs.push_back(mk(32'hC0200000, 1, 3'd0, 0, 64'hFFFFFFFE, 5'h01, 25));
        vecs.push_back(mk(32'hC0200000, 1, 3'd4, 0, 64'hFFFFFFFD, 5'h01, 0));
        vecs.push_back(mk(32'hC0200000, 1, 3'd2, 0, 64'hFFFFFFFD, 5'h01, 0));
        vecs.push_back(mk(32'hC0200000, 1, 3'd3, 0, 64'hFFFFFFFE, 5'h01, 0));
        vecs.push_back(mk(32'h4F000000, 1, 3'd0, 0, 64'h7FFFFFFF, 5'h10, 11));
        vecs.push_back(mk(32'h4F000000, 0, 3'd0, 0, 64'h80000000, 5'h00, 0));
        vecs.push_back(mk(32'hCF000000, 1, 3'd0, 0, 64'h80000000, 5'h00, 0));
        vecs.push_back(mk(32'h7FC00000, 1, 3'd0, 0, 64'h7FFFFFFF, 5'h10, 2));
        vecs.push_back(mk(32'hBF000000, 0, 3'd1, 0, 64'h0,        5'h01, 0));
        vecs.push_back(mk(32'hBF800000, 0, 3'd1, 0, 64'h0,        5'h10, 0));
        vecs.push_back(mk(32'h3F800000, 1, 3'd0, 0, 64'h1,        5'h00, 26));
        vecs.push_back(mk(32'h4B000000, 1, 3'd0, 0, 64'h00800000, 5'h00, 3));
        vecs.push_back(mk(32'h00000000, 1, 3'd0, 0, 64'h0,        5'h00, 2));
        vecs.push_back(mk(32'hFF800000, 1, 3'd0, 0, 64'h80000000, 5'h10, 2));
        vecs.push_back(mk(32'h7F800000, 0, 3'd0, 0, 64'hFFFFFFFF, 5'h10, 0));
        vecs.push_back(mk(32'h406CCCCD, 1, 3'd5, 0, 64'h3,        5'h01, 0));
        vecs.push_back(mk(32'h3F000000, 1, 3'd0, 0, 64'h0,        5'h01, 27));
        vecs.push_back(mk(32'h3FC00000, 1, 3'd0, 0, 64'h2,        5'h01, 0));
        vecs.push_back(mk(32'h00000001, 1, 3'd3, 0, 64'h1,        5'h01, 28));
        vecs.push_back(mk(32'h3F800000, 1, 3'd0, 1, 64'h1,        5'h00, 6));
        vecs.push_back(mk(32'h5F000000, 1, 3'd0, 1, 64'h7FFFFFFFFFFFFFFF, 5'h10, 8));
        vecs.push_back(mk(32'h4F000000, 1, 3'd0, 1, 64'h0000000080000000, 5'h00, 0));
        vecs.push_back(mk(32'hC0200000, 1, 3'd4, 1, 64'hFFFFFFFFFFFFFFFD, 5'h01, 0));
        vecs.push_back(mk(32'h406CCCCD, 1, 3'd0, 1, 64'h4,        5'h01, 6));

        // Reset state; in_valid is held high during reset and must be ignored.
        in_valid = 1'b1; in_a = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready32", {63'b0, rdy32}, 64'd0);
        check("rst in_ready64", {63'b0, rdy64}, 64'd0);
        check("rst out_valid", {63'b0, ov32}, 64'd0);
        check("rst out_z", {32'b0, z32}, 64'd0);
        check("rst out_flags", {59'b0, f32}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post-rst in_ready", {62'b0, rdy64, rdy32}, 64'd3);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov32 || ov64) seen = 1'b1;
        end
        check("rst operand ignored", {63'b0, seen}, 64'd0);

        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].sg, vecs[i].rm);
            if (vecs[i].w64) begin
                check($sformatf("v%0d z64", i), r_z64, vecs[i].z);
                check($sformatf("v%0d flags64", i), {59'b0, r_f64}, {59'b0, vecs[i].f});
                if (vecs[i].lat != 0)
                    check($sformatf("v%0d lat64", i), 64'(r_l64), 64'(vecs[i].lat));
            end else begin
                check($sformatf("v%0d z32", i), {32'b0, r_z32}, vecs[i].z);
                check($sformatf("v%0d flags32", i), {59'b0, r_f32}, {59'b0, vecs[i].f});
                if (vecs[i].lat != 0)
                    check($sformatf("v%0d lat32", i), 64'(r_l32), 64'(vecs[i].lat));
            end
        end

        // Backpressure: result must hold for 5 cycles with in_ready low.
        out_ready = 1'b0;
        launch(32'h406CCCCD, 1'b1, 3'd0);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (ov32) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("bp out_valid rise", {63'b0, seen}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", c), {63'b0, ov32}, 64'd1);
            check($sformatf("bp%0d out_z", c), {32'b0, z32}, 64'd4);
            check($sformatf("bp%0d flags", c), {59'b0, f32}, 64'h01);
            check($sformatf("bp%0d in_ready", c), {63'b0, rdy32}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", {62'b0, ov64, ov32}, 64'd0);
        check("bp release in_ready", {62'b0, rdy64, rdy32}, 64'd3);

        // Reset pulse while both instances are shifting 1.0.
        launch(32'h3F800000, 1'b1, 3'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid-rst in_ready", {62'b0, rdy64, rdy32}, 64'd3);
        seen = 1'b0;
        repeat (30) begin
            if (ov32 || ov64) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("mid-rst no out_valid", {63'b0, seen}, 64'd0);

        run(32'hC0200000, 1'b1, 3'd4);
        check("after-rst z32", {32'b0, r_z32}, 64'hFFFFFFFD);
        check("after-rst flags32", {59'b0, r_f32}, 64'h01);
        check("after-rst z64", r_z64, 64'hFFFFFFFFFFFFFFFD);
        check("after-rst lat32", 64'(r_l32), 64'd25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
